// File: rtl/store_buf_pkg.sv
// rtl/store_buf_pkg.sv - shared constants and entry type for the store buffer
package store_buf_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - store-to-load match, youngest valid entry wins (used under STORE_BUF_FWD_EN)
import store_buf_pkg::*;

module sb_fwd_match #(
   parameter  int DEPTH = SB_DEPTH,
   parameter  int AW    = SB_AW,
   parameter  int DW    = SB_DW,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH*AW-1:0] addr_flat,
   input  logic [DEPTH*DW-1:0] data_flat,
   input  logic [PW-1:0]       rd_ptr,
   input  logic [CW-1:0]       count,
   input  logic [AW-1:0]       ld_addr,
   output logic                hit,
   output logic [DW-1:0]       data
);

   logic [PW-1:0] idx;

   // Walk entries oldest to youngest so a later (younger) match overrides an older one
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PW'(k);
         if ((CW'(k) < count) && (addr_flat[idx*AW +: AW] == ld_addr)) begin
            hit  = 1'b1;
            data = data_flat[idx*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between core store port and data memory; STORE_BUF_FWD_EN enables load forwarding
import store_buf_pkg::*;

module store_buffer #(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [AW-1:0] ld_addr,
   output logic          fwd_hit,
   output logic [DW-1:0] fwd_data,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // Status comes only from the registered count, never from cpu_we or mem_ready
   assign cpu_stall = (count == CW'(DEPTH));
   assign mem_valid = (count != '0);
   assign empty     = (count == '0);
   assign push      = cpu_we && !cpu_stall;
   assign pop       = mem_valid && mem_ready;

   // Head is forced to zero when empty so stale storage never shows on the port
   assign mem_addr  = mem_valid ? addr_q[rd_ptr] : '0;
   assign mem_wdata = mem_valid ? data_q[rd_ptr] : '0;

   // Entry storage is deliberately not reset; only valid entries are ever observed
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= cpu_addr;
         data_q[wr_ptr] <= cpu_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic [DEPTH*AW-1:0] addr_flat;
   logic [DEPTH*DW-1:0] data_flat;

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign addr_flat[i*AW +: AW] = addr_q[i];
      assign data_flat[i*DW +: DW] = data_q[i];
   end

   sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
      .addr_flat (addr_flat),
      .data_flat (data_flat),
      .rd_ptr    (rd_ptr),
      .count     (count),
      .ld_addr   (ld_addr),
      .hit       (fwd_hit),
      .data      (fwd_data)
   );
`else
   logic unused_ld_addr;
   assign unused_ld_addr = ^ld_addr;
   assign fwd_hit        = 1'b0;
   assign fwd_data       = '0;
`endif

endmodule
